// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit multiplexed 7-segment scanner with per-slot anti-ghost guard,
// leading-zero blanking and frame-synchronous double-buffered digit loading.
module display_scan_ctrl #(
   parameter int PRESCALE = 1000,
   parameter int GUARD    = 4,
   parameter bit BLANK_LZ = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] digit_data,
   input  logic        load,
   input  logic        blank,
   output logic        load_ack,
   output logic        frame_tick,
   output logic [6:0]  seg,
   output logic [3:0]  an
);
   typedef enum logic {S_GUARD, S_DRIVE} state_t;
   localparam logic [15:0] LAST = 16'(PRESCALE - 1);
   localparam logic [15:0] GRD  = 16'(GUARD);
   state_t      state, state_d;
   logic [15:0] cnt, cnt_d, displayed, pending;
   logic [1:0]  idx;
   logic        pending_valid, wrap, frame_end, xfer, lz_blank;
   logic [3:0]  nib, an_d;
   logic [6:0]  seg_d;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h3F;
         4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;
         4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;
         4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;
         4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;
         4'h9: decode = 7'h6F;
         4'hA: decode = 7'h40;
         4'hB: decode = 7'h79;
         default: decode = 7'h00;
      endcase
   endfunction

   assign wrap       = cnt == LAST;
   assign frame_end  = wrap && idx == 2'd3;
   assign frame_tick = frame_end;
   assign xfer       = frame_end && (load || pending_valid);
   assign cnt_d      = wrap ? 16'd0 : cnt + 16'd1;
   assign nib        = displayed[{idx, 2'b00} +: 4];
   // a digit is a leading zero when it and every nibble above it are zero
   assign lz_blank   = BLANK_LZ && idx != 2'd0 && (displayed >> {idx, 2'b00}) == 16'd0;

   always_comb begin
      state_d = state == S_GUARD ? (cnt_d == GRD ? S_DRIVE : S_GUARD) : (wrap ? S_GUARD : S_DRIVE);
      an_d    = 4'b0000;
      seg_d   = 7'h00;
      if (state == S_DRIVE && !blank) begin
         an_d  = 4'b0001 << idx;
         seg_d = lz_blank ? 7'h00 : decode(nib);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state         <= S_GUARD;
         cnt           <= 16'd0;
         idx           <= 2'd0;
         displayed     <= 16'h0000;
         pending       <= 16'h0000;
         pending_valid <= 1'b0;
         an            <= 4'b0000;
         seg           <= 7'h00;
         load_ack      <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         an       <= an_d;
         seg      <= seg_d;
         load_ack <= xfer;
         if (wrap) idx <= idx + 2'd1;
         // transfers happen only at the frame boundary so one frame never mixes values
         if (frame_end) begin
            if (xfer) displayed <= load ? digit_data : pending;
            pending_valid <= 1'b0;
         end else if (load) begin
            pending       <= digit_data;
            pending_valid <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed vector bench for display_scan_ctrl at PRESCALE=8, GUARD=2,
// running a leading-zero-blanking instance and a non-blanking instance side by side.
module tb_display_scan_ctrl;
   typedef logic [3:0][6:0] seg4_t;
   typedef struct {
      logic [15:0] first;
      logic [15:0] last;
      seg4_t       lz1;
      seg4_t       lz0;
   } vec_t;

   logic        CLK = 1'b0, RESET = 1'b1, load = 1'b0, blank = 1'b0;
   logic [15:0] digit_data = 16'h0000;
   logic        ack1, ack0, ft1, ft0;
   logic [6:0]  seg1, seg0;
   logic [3:0]  an1, an0;
   int          checks = 0, errors = 0;
   vec_t        vecs[8];
   seg4_t       p1, p0;

   localparam seg4_t ZERO1 = {7'h00, 7'h00, 7'h00, 7'h3F};
   localparam seg4_t ZERO0 = {7'h3F, 7'h3F, 7'h3F, 7'h3F};

   display_scan_ctrl #(.PRESCALE(8), .GUARD(2), .BLANK_LZ(1'b1)) u_lz (
      .CLK(CLK), .RESET(RESET), .digit_data(digit_data), .load(load), .blank(blank),
      .load_ack(ack1), .frame_tick(ft1), .seg(seg1), .an(an1));
   display_scan_ctrl #(.PRESCALE(8), .GUARD(2), .BLANK_LZ(1'b0)) u_nlz (
      .CLK(CLK), .RESET(RESET), .digit_data(digit_data), .load(load), .blank(blank),
      .load_ack(ack0), .frame_tick(ft0), .seg(seg0), .an(an0));

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_an", {28'd0, an1}, 32'd0);
      chk("rst_seg", {25'd0, seg1}, 32'd0);
      chk("rst_ack", {31'd0, ack1}, 32'd0);
      chk("rst_ft", {31'd0, ft1}, 32'd0);
      chk("rst_an_nlz", {28'd0, an0}, 32'd0);
      chk("rst_seg_nlz", {25'd0, seg0}, 32'd0);
   endtask

   // Starts at frame cycle 0 and ends at the next frame's cycle 0.
   // Output sampled in cycle t+1 reflects the state of cycle t.
   task automatic check_frame(input seg4_t e1, input seg4_t e0, input int la, input logic [15:0] da,
                              input int lb, input logic [15:0] db, input int bf, input int bl,
                              input logic ack_exp);
      for (int t = 0; t < 32; t++) begin
         logic on;
         logic [3:0] ea;
         chk("frame_tick", {31'd0, ft1}, {31'd0, t == 31});
         chk("frame_tick_nlz", {31'd0, ft0}, {31'd0, t == 31});
         load       = (t == la) || (t == lb);
         digit_data = (t == lb) ? db : da;
         blank      = (t >= bf) && (t < bf + bl);
         tick();
         on = (t % 8 >= 2) && !((t >= bf) && (t < bf + bl));
         ea = on ? 4'b0001 << (t / 8) : 4'b0000;
         chk("an", {28'd0, an1}, {28'd0, ea});
         chk("an_nlz", {28'd0, an0}, {28'd0, ea});
         chk("seg", {25'd0, seg1}, {25'd0, on ? e1[t / 8] : 7'h00});
         chk("seg_nlz", {25'd0, seg0}, {25'd0, on ? e0[t / 8] : 7'h00});
         chk("load_ack", {31'd0, ack1}, {31'd0, (t == 31) ? ack_exp : 1'b0});
      end
      load  = 1'b0;
      blank = 1'b0;
   endtask

   initial begin
      vecs = '{
         '{16'h1234, 16'h1234, {7'h06, 7'h5B, 7'h4F, 7'h66}, {7'h06, 7'h5B, 7'h4F, 7'h66}},
         '{16'h0042, 16'h0905, {7'h00, 7'h6F, 7'h3F, 7'h6D}, {7'h3F, 7'h6F, 7'h3F, 7'h6D}},
         '{16'h0007, 16'h0007, {7'h00, 7'h00, 7'h00, 7'h07}, {7'h3F, 7'h3F, 7'h3F, 7'h07}},
         '{16'h0CBA, 16'h0CBA, {7'h00, 7'h00, 7'h79, 7'h40}, {7'h3F, 7'h00, 7'h79, 7'h40}},
         '{16'h0999, 16'h0000, ZERO1, ZERO0},
         '{16'h0100, 16'h0100, {7'h00, 7'h06, 7'h3F, 7'h3F}, {7'h3F, 7'h06, 7'h3F, 7'h3F}},
         '{16'h86DF, 16'h86DF, {7'h7F, 7'h7D, 7'h00, 7'h00}, {7'h7F, 7'h7D, 7'h00, 7'h00}},
         '{16'h5E08, 16'h5E08, {7'h6D, 7'h00, 7'h3F, 7'h7F}, {7'h6D, 7'h00, 7'h3F, 7'h7F}}
      };
      repeat (3) tick();
      chk_reset();
      RESET = 1'b0;
      p1 = ZERO1;
      p0 = ZERO0;
      foreach (vecs[i]) begin
         check_frame(p1, p0, 9, vecs[i].first, 20, vecs[i].last, -1, 0, 1'b1);
         p1 = vecs[i].lz1;
         p0 = vecs[i].lz0;
      end
      check_frame(p1, p0, -1, 16'h0, -1, 16'h0, 10, 5, 1'b0);
      check_frame(p1, p0, 31, 16'hB000, -1, 16'h0, -1, 0, 1'b1);
      p1 = {7'h79, 7'h3F, 7'h3F, 7'h3F};
      check_frame(p1, p1, -1, 16'h0, -1, 16'h0, -1, 0, 1'b0);
      begin
         int acks = 0;
         load       = 1'b1;
         digit_data = 16'h0001;
         for (int c = 1; c <= 96; c++) begin
            tick();
            chk("hold_ack", {31'd0, ack1}, {31'd0, c == 32 || c == 64});
            if (ack1 === 1'b1) acks++;
            if (c == 64) load = 1'b0;
         end
         chk("hold_ack_count", acks, 32'd2);
      end
      check_frame({7'h00, 7'h00, 7'h00, 7'h06}, {7'h3F, 7'h3F, 7'h3F, 7'h06},
                  -1, 16'h0, -1, 16'h0, -1, 0, 1'b0);
      for (int t = 0; t < 20; t++) begin
         load       = (t == 5);
         digit_data = 16'h1111;
         tick();
      end
      load  = 1'b0;
      RESET = 1'b1;
      repeat (3) tick();
      chk_reset();
      RESET = 1'b0;
      check_frame(ZERO1, ZERO0, -1, 16'h0, -1, 16'h0, -1, 0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
